// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and layout helpers for the MMIO hub.
//   region_e       : address decode result (RAM, VRAM, IO, unmapped)
//   IO_STATUS/CH0  : word offsets inside the IO window
//   io_frame_word  : word offset of the FRAME register for a given channel count
//   st_*           : STATUS bit positions as functions of the channel count
package mmio_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_VRAM, REG_IO, REG_NONE} region_e;

  localparam int unsigned IO_STATUS = 0;
  localparam int unsigned IO_CH0    = 1;

  function automatic int unsigned io_frame_word(input int unsigned n_io);
    return n_io + 1;
  endfunction

  function automatic int unsigned st_ovf_lo(input int unsigned n_io);
    return n_io;
  endfunction

  function automatic int unsigned st_frame_bit(input int unsigned n_io);
    return 2 * n_io;
  endfunction

  function automatic int unsigned st_err_bit(input int unsigned n_io);
    return 2 * n_io + 1;
  endfunction

endpackage

// File: rtl/mmio_channel.sv
// mmio_channel: one input peripheral channel.
//   set/set_data : new-data strobe and payload from the peripheral
//   rd_clr       : CPU read of this channel's word (clears valid)
//   ovf_clr      : write-1-to-clear of the overflow flag
//   hold         : holding register
//   vld/ovf      : valid and overflow flags
//   ack          : one-cycle pulse the cycle after a consuming read
module mmio_channel #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [DATA_W-1:0] set_data,
  input  logic              rd_clr,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] hold,
  output logic              vld,
  output logic              ovf,
  output logic              ack
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      vld  <= 1'b0;
      ovf  <= 1'b0;
      ack  <= 1'b0;
    end else begin
      ack <= rd_clr;
      // New data wins over a same-cycle consuming read; the read already
      // captured the old contents this cycle.
      if (set) begin
        hold <= set_data;
        vld  <= 1'b1;
      end else if (rd_clr) begin
        vld  <= 1'b0;
      end
      // Any new data arriving while valid is set counts as an overflow.
      if (set && vld)   ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: CPU-side address decoder and read mux for RAM, VRAM and a small
// peripheral register file (STATUS, N_IO channel registers, FRAME).
//   clk, rst_n                : clock, synchronous active-low reset
//   we, re, addr, wdata, rdata: CPU bus; rdata valid one cycle after re
//   ram_*  / vram_*           : memory ports (combinational address/we)
//   ch_data, ch_valid, ch_ack : peripheral channels (N_IO x DATA_W data)
//   vsync, vsync_ack          : frame sync level and clear acknowledge
//   err                       : sticky bus-error flag
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RAM_BASE  = 'h0000,
  parameter int                RAM_AW    = 12,
  parameter logic [ADDR_W-1:0] IO_BASE   = 'h4000,
  parameter logic [ADDR_W-1:0] VRAM_BASE = 'h8000,
  parameter int                VRAM_AW   = 13,
  parameter int                N_IO      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ram_we,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic                     vram_we,
  output logic [VRAM_AW-1:0]       vram_addr,
  output logic [DATA_W-1:0]        vram_wdata,
  input  logic [DATA_W-1:0]        vram_rdata,
  input  logic [N_IO*DATA_W-1:0]   ch_data,
  input  logic [N_IO-1:0]          ch_valid,
  output logic [N_IO-1:0]          ch_ack,
  input  logic                     vsync,
  output logic                     vsync_ack,
  output logic                     err
);

  localparam logic [ADDR_W:0] RAM_SIZE  = (ADDR_W+1)'(1) << (RAM_AW + 2);
  localparam logic [ADDR_W:0] VRAM_SIZE = (ADDR_W+1)'(1) << (VRAM_AW + 2);
  localparam logic [ADDR_W:0] IO_SIZE   = (ADDR_W+1)'(4 * (N_IO + 2));
  localparam int              OVF_LO    = int'(st_ovf_lo(N_IO));
  localparam int              FRAME_BIT = int'(st_frame_bit(N_IO));
  localparam int              ERR_BIT   = int'(st_err_bit(N_IO));
  localparam logic [3:0]      STATUS_W  = 4'(IO_STATUS);
  localparam logic [3:0]      FRAME_W   = 4'(io_frame_word(N_IO));

  // Offsets are one bit wider than the address so an address below a base
  // wraps to a value with the top bit set and fails the size compare.
  logic [ADDR_W:0] ram_off, vram_off, io_off;
  logic [3:0]      io_idx;
  region_e         region;

  assign ram_off  = {1'b0, addr} - {1'b0, RAM_BASE};
  assign vram_off = {1'b0, addr} - {1'b0, VRAM_BASE};
  assign io_off   = {1'b0, addr} - {1'b0, IO_BASE};
  assign io_idx   = io_off[5:2];

  always_comb begin
    region = REG_NONE;
    if (io_off < IO_SIZE)            region = REG_IO;
    else if (vram_off < VRAM_SIZE)   region = REG_VRAM;
    else if (ram_off < RAM_SIZE)     region = REG_RAM;
  end

  assign ram_addr   = ram_off[RAM_AW+1:2];
  assign vram_addr  = vram_off[VRAM_AW+1:2];
  assign ram_wdata  = wdata;
  assign vram_wdata = wdata;
  assign ram_we     = rst_n & we & (region == REG_RAM);
  assign vram_we    = rst_n & we & (region == REG_VRAM);

  // A write takes precedence over a simultaneous read.
  logic rd_vld, io_rd, status_w1c, frame_rd_clr, err_set;
  assign rd_vld       = re & ~we;
  assign io_rd        = rd_vld & (region == REG_IO);
  assign frame_rd_clr = io_rd & (io_idx == FRAME_W);
  assign status_w1c   = we & (region == REG_IO) & (io_idx == STATUS_W);
  assign err_set      = ((re | we) & (region == REG_NONE)) | (re & we);

  // Channels
  logic [N_IO-1:0][DATA_W-1:0] ch_hold;
  logic [N_IO-1:0]             ch_vld, ch_ovf, ch_rd_clr, ch_ovf_clr;

  always_comb begin
    ch_rd_clr = '0;
    for (int k = 0; k < N_IO; k++)
      ch_rd_clr[k] = io_rd & (io_idx == 4'(IO_CH0 + k));
  end

  assign ch_ovf_clr = status_w1c ? wdata[OVF_LO +: N_IO] : '0;

  for (genvar i = 0; i < N_IO; i++) begin : g_ch
    mmio_channel #(.DATA_W(DATA_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (ch_valid[i]),
      .set_data (ch_data[i*DATA_W +: DATA_W]),
      .rd_clr   (ch_rd_clr[i]),
      .ovf_clr  (ch_ovf_clr[i]),
      .hold     (ch_hold[i]),
      .vld      (ch_vld[i]),
      .ovf      (ch_ovf[i]),
      .ack      (ch_ack[i])
    );
  end

  // IO read value, captured in the read cycle (before any flag update)
  logic              frame, vs_q;
  logic [DATA_W-1:0] status, io_val;

  always_comb begin
    status                     = '0;
    status[N_IO-1:0]           = ch_vld;
    status[OVF_LO +: N_IO]     = ch_ovf;
    status[FRAME_BIT]          = frame;
    status[ERR_BIT]            = err;
  end

  always_comb begin
    io_val = '0;
    if (io_idx == STATUS_W)     io_val = status;
    else if (io_idx == FRAME_W) io_val[0] = frame;
    else begin
      for (int k = 0; k < N_IO; k++)
        if (io_idx == 4'(IO_CH0 + k)) io_val = ch_hold[k];
    end
  end

  // Read path: registered select; memories supply data in the next cycle.
  logic              rd_pend;
  region_e           sel_q;
  logic [DATA_W-1:0] io_q, hold_q, rd_mux;

  always_comb begin
    rd_mux = '0;
    case (sel_q)
      REG_RAM:  rd_mux = ram_rdata;
      REG_VRAM: rd_mux = vram_rdata;
      REG_IO:   rd_mux = io_q;
      default:  rd_mux = '0;
    endcase
    rdata = rd_pend ? rd_mux : hold_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      frame     <= 1'b0;
      err       <= 1'b0;
      vsync_ack <= 1'b0;
      rd_pend   <= 1'b0;
      sel_q     <= REG_NONE;
      io_q      <= '0;
      hold_q    <= '0;
    end else begin
      vs_q      <= vsync;
      vsync_ack <= frame_rd_clr;
      if (vsync & ~vs_q)                                      frame <= 1'b1;
      else if (frame_rd_clr | (status_w1c & wdata[FRAME_BIT])) frame <= 1'b0;
      if (err_set)                             err <= 1'b1;
      else if (status_w1c & wdata[ERR_BIT])    err <= 1'b0;
      rd_pend <= rd_vld;
      if (rd_vld) begin
        sel_q <= region;
        io_q  <= io_val;
      end
      // Freeze whatever was presented so rdata holds between reads.
      if (rd_pend) hold_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Randomized + directed bench for mmio_hub with a scoreboard. A driver issues
// one bus cycle per clock and pushes the expected outputs for that cycle from
// a behavioural model; an independent monitor pops and compares at negedge.
module tb_mmio_hub;
  localparam int NIO = 2;
  localparam int R_RAM = 0, R_VRAM = 1, R_IO = 2, R_NONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, we, re, ram_we, vram_we, vsync, vsync_ack, err;
  logic [31:0] addr, wdata, rdata, ram_wdata, ram_rdata, vram_wdata, vram_rdata;
  logic [11:0] ram_addr;
  logic [12:0] vram_addr;
  logic [63:0] ch_data;
  logic [1:0]  ch_valid, ch_ack;

  mmio_hub dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .ch_data(ch_data),
    .ch_valid(ch_valid), .ch_ack(ch_ack), .vsync(vsync), .vsync_ack(vsync_ack),
    .err(err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  ack;
    logic        vack, err, ram_we, vram_we;
    logic [11:0] ram_addr;
    logic [12:0] vram_addr;
    logic [31:0] wd;
    bit          dchk;
    logic [31:0] dval;
    string       dname;
  } exp_t;

  exp_t scb[$];
  int   n_chk = 0, n_fail = 0;

  // next-cycle stimulus (n_*) and stimulus currently on the pins (c_*)
  logic        n_rst = 0, n_we = 0, n_re = 0, n_vs = 0;
  logic [31:0] n_addr = 0, n_wd = 0, n_cd0 = 0, n_cd1 = 0, n_ram = 0, n_vram = 0;
  logic [1:0]  n_cv = 0;
  bit          n_dchk = 0;
  logic [31:0] n_dval = 0;
  string       n_dname = "";
  logic        c_rst = 0, c_we = 0, c_re = 0, c_vs = 0;
  logic [31:0] c_addr = 0, c_wd = 0, c_cd0 = 0, c_cd1 = 0, c_ram = 0, c_vram = 0;
  logic [1:0]  c_cv = 0;

  // behavioural model state
  logic [31:0] m_hold [NIO];
  bit          m_valid[NIO], m_ovf[NIO], m_ack[NIO];
  bit          m_frame, m_err, m_vsp, m_vack, m_pend;
  int          m_preg;
  logic [31:0] m_pio, m_rdata;

  function automatic int region_of(input logic [31:0] a);
    if (a >= 32'h4000 && a < 32'h4000 + 4 * (NIO + 2)) return R_IO;
    if (a >= 32'h8000 && a < 32'h8000 + 4 * 8192)      return R_VRAM;
    if (a < 4 * 4096)                                  return R_RAM;
    return R_NONE;
  endfunction

  function automatic logic [31:0] io_word(input int idx);
    logic [31:0] v = 0;
    if (idx == 0) begin
      for (int k = 0; k < NIO; k++) begin
        if (m_valid[k]) v += 32'd1 << k;
        if (m_ovf[k])   v += 32'd1 << (NIO + k);
      end
      if (m_frame) v += 32'd1 << (2 * NIO);
      if (m_err)   v += 32'd1 << (2 * NIO + 1);
    end else if (idx >= 1 && idx <= NIO) v = m_hold[idx-1];
    else if (idx == NIO + 1)             v = {31'd0, m_frame};
    return v;
  endfunction

  // Apply one clock edge to the model using the inputs of the ending cycle.
  task automatic model_edge();
    int rg, idx;
    bit rd, w1c, cv;
    logic [31:0] off;
    if (!c_rst) begin
      for (int k = 0; k < NIO; k++) begin
        m_hold[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; m_ack[k] = 0;
      end
      m_frame = 0; m_err = 0; m_vsp = 0; m_vack = 0; m_pend = 0; m_rdata = 0;
      return;
    end
    rg   = region_of(c_addr);
    off  = (c_addr - 32'h4000) >> 2;
    idx  = int'(off);
    rd   = c_re && !c_we;
    w1c  = c_we && rg == R_IO && idx == 0;
    m_pio  = io_word(idx);
    m_pend = rd;
    m_preg = rg;
    for (int k = 0; k < NIO; k++) m_ack[k] = rd && rg == R_IO && idx == k + 1;
    m_vack = rd && rg == R_IO && idx == NIO + 1;
    if (((c_re || c_we) && rg == R_NONE) || (c_re && c_we)) m_err = 1;
    else if (w1c && c_wd[2*NIO+1])                          m_err = 0;
    if (c_vs && !m_vsp)                            m_frame = 1;
    else if (m_vack || (w1c && c_wd[2*NIO]))       m_frame = 0;
    m_vsp = c_vs;
    for (int k = 0; k < NIO; k++) begin
      cv = c_cv[k];
      if (cv && m_valid[k])           m_ovf[k] = 1;
      else if (w1c && c_wd[NIO + k])  m_ovf[k] = 0;
      if (cv) begin
        m_hold[k]  = (k == 0) ? c_cd0 : c_cd1;
        m_valid[k] = 1;
      end else if (m_ack[k]) m_valid[k] = 0;
    end
  endtask

  task automatic step();
    exp_t e;
    logic [31:0] voff;
    @(posedge clk);
    model_edge();
    #1;
    c_rst = n_rst; c_we = n_we; c_re = n_re; c_addr = n_addr; c_wd = n_wd;
    c_cv = n_cv; c_cd0 = n_cd0; c_cd1 = n_cd1; c_vs = n_vs; c_ram = n_ram; c_vram = n_vram;
    rst_n = c_rst; we = c_we; re = c_re; addr = c_addr; wdata = c_wd;
    ch_valid = c_cv; ch_data = {c_cd1, c_cd0}; vsync = c_vs;
    ram_rdata = c_ram; vram_rdata = c_vram;
    if (m_pend) begin
      case (m_preg)
        R_RAM:   m_rdata = c_ram;
        R_VRAM:  m_rdata = c_vram;
        R_IO:    m_rdata = m_pio;
        default: m_rdata = 0;
      endcase
      m_pend = 0;
    end
    voff        = c_addr - 32'h8000;
    e.rdata     = m_rdata;
    e.ack       = {m_ack[1], m_ack[0]};
    e.vack      = m_vack;
    e.err       = m_err;
    e.ram_we    = c_rst && c_we && region_of(c_addr) == R_RAM;
    e.vram_we   = c_rst && c_we && region_of(c_addr) == R_VRAM;
    e.ram_addr  = c_addr[13:2];
    e.vram_addr = voff[14:2];
    e.wd        = c_wd;
    e.dchk      = n_dchk;
    e.dval      = n_dval;
    e.dname     = n_dname;
    scb.push_back(e);
    n_we = 0; n_re = 0; n_cv = 0; n_dchk = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    n_we = 1; n_addr = a; n_wd = d; step();
  endtask
  task automatic rd(input logic [31:0] a);
    n_re = 1; n_addr = a; step();
  endtask
  task automatic expect_rd(input string nm, input logic [31:0] v);
    n_dchk = 1; n_dval = v; n_dname = nm; step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() != 0) begin
        e = scb.pop_front();
        chk("rdata",     rdata,                 e.rdata);
        chk("ch_ack",    {30'd0, ch_ack},       {30'd0, e.ack});
        chk("vsync_ack", {31'd0, vsync_ack},    {31'd0, e.vack});
        chk("err",       {31'd0, err},          {31'd0, e.err});
        chk("ram_we",    {31'd0, ram_we},       {31'd0, e.ram_we});
        chk("vram_we",   {31'd0, vram_we},      {31'd0, e.vram_we});
        chk("ram_addr",  {20'd0, ram_addr},     {20'd0, e.ram_addr});
        chk("vram_addr", {19'd0, vram_addr},    {19'd0, e.vram_addr});
        chk("ram_wdata", ram_wdata,             e.wd);
        chk("vram_wdata", vram_wdata,           e.wd);
        if (e.dchk) chk(e.dname, rdata, e.dval);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; we = 0; re = 0; addr = 0; wdata = 0; ch_valid = 0; ch_data = 0;
    vsync = 0; ram_rdata = 0; vram_rdata = 0;
    step(); step();
    n_rst = 1;
    step();

    // RAM write/read
    wr(32'h4, 32'hF);
    rd(32'h4);
    n_ram = 32'h999; expect_rd("ram_read", 32'h999);
    // VRAM write/read
    wr(32'h8008, 32'h1234);
    rd(32'h8008);
    n_vram = 32'h24A; expect_rd("vram_read", 32'h24A);
    // channel 0 data, status, consume
    n_cv = 2'b01; n_cd0 = 32'h666; step();
    rd(32'h4000); expect_rd("status_valid0", 32'h1);
    rd(32'h4004); expect_rd("ch0_read", 32'h666);
    step();
    rd(32'h4000); expect_rd("status_cleared", 32'h0);
    // channel 1 overflow, W1C
    n_cv = 2'b10; n_cd1 = 32'h1; step();
    n_cv = 2'b10; n_cd1 = 32'h2; step();
    rd(32'h4000); expect_rd("status_ovf1", 32'hA);
    wr(32'h4000, 32'h8);
    rd(32'h4000); expect_rd("status_ovf1_clr", 32'h2);
    // frame flag
    n_vs = 1; step();
    rd(32'h4000); expect_rd("status_frame", 32'h12);
    rd(32'h400C); expect_rd("frame_read", 32'h1);
    // set beats clear on channel 0
    n_cv = 2'b01; n_cd0 = 32'h777; step();
    n_cv = 2'b01; n_cd0 = 32'h888; rd(32'h4004);
    expect_rd("set_beats_clear", 32'h777);
    rd(32'h4000); expect_rd("status_after_coinc", 32'h7);
    rd(32'h4004); expect_rd("ch0_new_data", 32'h888);
    // unmapped read, then reset with a read in flight
    n_vs = 0;
    rd(32'h4100); expect_rd("unmapped_read", 32'h0);
    n_re = 1; n_addr = 32'h4004; n_rst = 0; step();
    n_rst = 1; expect_rd("rdata_after_reset", 32'h0);
    rd(32'h4000); expect_rd("status_after_reset", 32'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int sel;
      sel    = int'($urandom_range(0, 9));
      n_we   = ($urandom_range(0, 3) == 0);
      n_re   = ($urandom_range(0, 2) == 0);
      n_wd   = $urandom;
      case (sel)
        0, 1:    n_addr = $urandom_range(0, 32'h3FFF);
        2:       n_addr = 32'h8000 + $urandom_range(0, 32'h7FFF);
        3:       n_addr = (($urandom_range(0, 3) == 0) ? 32'h4010 :
                          ($urandom_range(0, 1) == 0) ? 32'h10000 : 32'hFFFF_FFFC);
        default: n_addr = 32'h4000 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      endcase
      n_cv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      n_cd0  = $urandom;
      n_cd1  = $urandom;
      if ($urandom_range(0, 15) == 0) n_vs = ~n_vs;
      n_ram  = $urandom;
      n_vram = $urandom;
      n_rst  = ($urandom_range(0, 199) != 0);
      step();
    end

    n_rst = 1;
    step(); step(); step();
    for (int k = 0; k < 10 && scb.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    if (scb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", scb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
